// File: rtl/serial_pkg.sv
// Shared definitions for the 8N1 serial receiver and transmitter: FSM encodings, bit-timing math, status flags.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package serial_pkg;

  // Receiver/transmitter FSM states; the encoding is visible on db_estado.
  typedef enum logic [3:0] {
    ESPERA   = 4'd0,
    INICIO   = 4'd1,
    DADOS    = 4'd2,
    PARADA   = 4'd3,
    ARMAZENA = 4'd4,
    FINAL    = 4'd5
  } estado_t;

  // Per-byte status flags kept together so they update as one record.
  typedef struct packed {
    logic tem_dado;
    logic erro_stop;
    logic erro_sobrescrita;
  } status_t;

  localparam int CLK_HZ_PADRAO = 50_000_000;
  localparam int BAUD_PADRAO   = 115_200;

  // Clock cycles per bit (integer division, truncating), never below one.
  function automatic int ticks_bit(input int clk_hz, input int baud);
    int m;
    m = clk_hz / baud;
    if (m < 1) m = 1;
    return m;
  endfunction

  // Clock cycles from the start edge to the middle of the start bit.
  function automatic int ticks_meio(input int clk_hz, input int baud);
    int h;
    h = ticks_bit(clk_hz, baud) / 2;
    if (h < 1) h = 1;
    return h;
  endfunction

endpackage

// File: rtl/contador_tick.sv
// Modulo-M tick counter: fim pulses on the cycle the count sits at M-1 while counting.
// Latency: fim is combinational from the current count; count updates on the next edge.
// Backpressure: none; zera overrides conta, conta stalls the count when low.
module contador_tick #(
  parameter int M = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] cnt;

  // Count 0..M-1 and wrap to 0; clear has priority over counting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (zera) begin
      cnt <= '0;
    end else if (conta) begin
      cnt <= (cnt == ULTIMO) ? '0 : cnt + W'(1);
    end
  end

  assign fim = conta && (cnt == ULTIMO);

endmodule

// File: rtl/rx_serial_8n1.sv
// 8N1 serial receiver: synchronizes the line, samples mid-bit, holds the last good byte with status flags.
// Latency: pronto pulses 9.5*M+2 cycles after the start edge leaves the 2-flop synchronizer.
// Backpressure: none on the line; an unread byte is flagged by tem_dado and an overwrite sets erro_sobrescrita.
module rx_serial_8n1
  import serial_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_PADRAO,
  parameter int BAUD   = BAUD_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  input  logic       recebe_dado,
  output logic [7:0] dados_ascii,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro_stop,
  output logic       erro_sobrescrita,
  output logic       db_recebendo,
  output logic [3:0] db_estado
);

  localparam int M  = ticks_bit(CLK_HZ, BAUD);
  localparam int M2 = ticks_meio(CLK_HZ, BAUD);

  estado_t    estado, prox;
  logic       sinc1, linha;
  logic [1:0] sinc_ok;
  logic       armado;
  logic [2:0] n_bits;
  logic [7:0] desloc;
  logic       stop_ok;
  logic [7:0] dados_q;
  status_t    st;

  logic conta_meio, conta_bit, fim_meio, fim_bit;
  logic desloca, amostra_stop;
  logic grava;

  // Half-bit timer for the start bit, full-bit timer for data and stop bits.
  contador_tick #(.M(M2)) u_cnt_meio (
    .clock (clock),
    .reset (reset),
    .zera  (!conta_meio),
    .conta (conta_meio),
    .fim   (fim_meio)
  );

  contador_tick #(.M(M)) u_cnt_bit (
    .clock (clock),
    .reset (reset),
    .zera  (!conta_bit),
    .conta (conta_bit),
    .fim   (fim_bit)
  );

  // Two-flop synchronizer idling high; sinc_ok marks when linha holds a real sample rather than the reset value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc1   <= 1'b1;
      linha   <= 1'b1;
      sinc_ok <= 2'b00;
    end else begin
      sinc1   <= entrada_serial;
      linha   <= sinc1;
      sinc_ok <= {sinc_ok[0], 1'b1};
    end
  end

  // Arm start detection only after a genuine high was seen in ESPERA, so a low stop bit or a frame cut by reset never re-triggers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armado <= 1'b0;
    end else if (estado != ESPERA) begin
      armado <= 1'b0;
    end else if (linha && sinc_ok[1]) begin
      armado <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= ESPERA;
    end else begin
      estado <= prox;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    prox         = estado;
    conta_meio   = 1'b0;
    conta_bit    = 1'b0;
    desloca      = 1'b0;
    amostra_stop = 1'b0;
    case (estado)
      ESPERA: begin
        if (armado && !linha) prox = INICIO;
      end
      INICIO: begin
        conta_meio = 1'b1;
        if (fim_meio) prox = linha ? ESPERA : DADOS;
      end
      DADOS: begin
        conta_bit = 1'b1;
        if (fim_bit) begin
          desloca = 1'b1;
          if (n_bits == 3'd7) prox = PARADA;
        end
      end
      PARADA: begin
        conta_bit = 1'b1;
        if (fim_bit) begin
          amostra_stop = 1'b1;
          prox         = ARMAZENA;
        end
      end
      ARMAZENA: prox = FINAL;
      FINAL:    prox = ESPERA;
      default:  prox = ESPERA;
    endcase
  end

  // Count data bits sampled in the current frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n_bits <= 3'd0;
    end else if (estado != DADOS) begin
      n_bits <= 3'd0;
    end else if (desloca) begin
      n_bits <= n_bits + 3'd1;
    end
  end

  // Shift data bits in LSB first; after eight shifts bit 0 lands in desloc[0].
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      desloc <= 8'h00;
    end else if (desloca) begin
      desloc <= {linha, desloc[7:1]};
    end
  end

  // Capture the stop bit at its mid point.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stop_ok <= 1'b0;
    end else if (amostra_stop) begin
      stop_ok <= linha;
    end
  end

  assign grava = (estado == ARMAZENA);

  // Output byte and status; a good frame's set of tem_dado beats a coincident acknowledge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dados_q <= 8'h00;
      st      <= '0;
    end else if (grava && stop_ok) begin
      dados_q            <= desloc;
      st.erro_stop        <= 1'b0;
      st.erro_sobrescrita <= st.tem_dado && !recebe_dado;
      st.tem_dado         <= 1'b1;
    end else begin
      if (grava) st.erro_stop <= 1'b1;
      if (recebe_dado) st.tem_dado <= 1'b0;
    end
  end

  assign dados_ascii      = dados_q;
  assign tem_dado         = st.tem_dado;
  assign erro_stop        = st.erro_stop;
  assign erro_sobrescrita = st.erro_sobrescrita;
  assign pronto           = (estado == FINAL);
  assign db_recebendo     = (estado != ESPERA);
  assign db_estado        = estado;

endmodule
